// File: rtl/dbgtcm_arbiter_pkg.sv
// Shared widths, access-size encodings and index types for the debug TCM arbiter.
// These values mirror the femto.vh bus macros, including the DBGTCM_ARB_PORTS count.
package dbgtcm_arbiter_pkg;

  localparam int BUS_WIDTH        = 32;
  localparam int BUS_ACC_WIDTH    = 2;
  localparam int DBGTCM_SIZE      = 256;
  localparam int DBGTCM_ARB_PORTS = 2;
  localparam int DBGTCM_AW        = $clog2(DBGTCM_SIZE);

  typedef enum logic [BUS_ACC_WIDTH-1:0] {
    BUS_ACC_1B = 2'd0,
    BUS_ACC_2B = 2'd1,
    BUS_ACC_4B = 2'd2
  } bus_acc_e;

  typedef logic [BUS_WIDTH-1:0]                bus_data_t;
  typedef logic [$clog2(DBGTCM_ARB_PORTS)-1:0] port_idx_t;

endpackage

// File: rtl/dbgtcm_arbiter_if.sv
// Request/response bus used both on the upstream ports and toward the TCM controller.
// The busy signal is only meaningful on the upstream side.
interface dbgtcm_arbiter_if
  import dbgtcm_arbiter_pkg::*;
#(
  parameter int AW = DBGTCM_AW
) ();

  logic [AW-1:0]            addr;
  logic                     w_rb;
  logic [BUS_ACC_WIDTH-1:0] acc;
  bus_data_t                wdata;
  logic                     req;
  bus_data_t                rdata;
  logic                     resp;
  logic                     fault;
  logic                     busy;

  modport master (
    output addr, w_rb, acc, wdata, req,
    input  rdata, resp, fault, busy
  );

  modport slave (
    input  addr, w_rb, acc, wdata, req,
    output rdata, resp, fault, busy
  );

endinterface

// File: rtl/dbgtcm_arb_slot.sv
// One-entry request buffer for a single arbiter port.
// Tracks whether the request is still buffered (pend) or granted and awaiting completion (infl).
module dbgtcm_arb_slot
  import dbgtcm_arbiter_pkg::*;
#(
  parameter int AW = DBGTCM_AW
) (
  input  logic                     clk,
  input  logic                     rstn,
  dbgtcm_arbiter_if.slave          port,
  input  logic                     grant,
  input  logic                     fault_in,
  input  logic                     resp_sel,
  input  bus_data_t                rdata_in,
  output logic                     pend,
  output logic [AW-1:0]            addr,
  output logic                     w_rb,
  output logic [BUS_ACC_WIDTH-1:0] acc,
  output bus_data_t                wdata
);

  logic infl;
  logic fault_q;
  logic busy;
  logic complete;

  assign busy = pend | infl;

  // A stray m_resp with nothing in flight (e.g. right after reset) must not surface.
  assign complete = rstn & resp_sel & infl;

  assign port.busy  = rstn & busy;
  assign port.fault = rstn & fault_q;
  assign port.resp  = complete;
  assign port.rdata = complete ? rdata_in : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend    <= 1'b0;
      infl    <= 1'b0;
      fault_q <= 1'b0;
      addr    <= '0;
      w_rb    <= 1'b0;
      acc     <= '0;
      wdata   <= '0;
    end else begin
      fault_q <= grant & fault_in;
      if (port.req && !busy) begin
        pend  <= 1'b1;
        addr  <= port.addr;
        w_rb  <= port.w_rb;
        acc   <= port.acc;
        wdata <= port.wdata;
      end
      if (complete) begin
        infl <= 1'b0;
      end
      if (grant) begin
        pend <= 1'b0;
        infl <= ~fault_in;
      end
    end
  end

endmodule

// File: rtl/dbgtcm_arbiter.sv
// Round-robin arbiter sharing the single-ported debug TCM controller between the CPU
// data bus (p0) and the debug transport (p1); one grant per cycle, responses routed back by owner.
module dbgtcm_arbiter
  import dbgtcm_arbiter_pkg::*;
#(
  parameter int AW = DBGTCM_AW
) (
  input  logic             clk,
  input  logic             rstn,
  dbgtcm_arbiter_if.slave  p0,
  dbgtcm_arbiter_if.slave  p1,
  dbgtcm_arbiter_if.master m
);

  logic [DBGTCM_ARB_PORTS-1:0] pend;
  logic [DBGTCM_ARB_PORTS-1:0] grant;
  logic [DBGTCM_ARB_PORTS-1:0] resp_sel;
  logic [AW-1:0]               s_addr  [DBGTCM_ARB_PORTS];
  logic                        s_w_rb  [DBGTCM_ARB_PORTS];
  logic [BUS_ACC_WIDTH-1:0]    s_acc   [DBGTCM_ARB_PORTS];
  bus_data_t                   s_wdata [DBGTCM_ARB_PORTS];

  port_idx_t                rr;
  port_idx_t                owner;
  port_idx_t                sel;
  logic                     any;
  logic [AW-1:0]            hold_addr;
  logic                     hold_w_rb;
  logic [BUS_ACC_WIDTH-1:0] hold_acc;
  bus_data_t                hold_wdata;

  dbgtcm_arb_slot #(.AW(AW)) u_slot0 (
    .clk      (clk),
    .rstn     (rstn),
    .port     (p0),
    .grant    (grant[0]),
    .fault_in (m.fault),
    .resp_sel (resp_sel[0]),
    .rdata_in (m.rdata),
    .pend     (pend[0]),
    .addr     (s_addr[0]),
    .w_rb     (s_w_rb[0]),
    .acc      (s_acc[0]),
    .wdata    (s_wdata[0])
  );

  dbgtcm_arb_slot #(.AW(AW)) u_slot1 (
    .clk      (clk),
    .rstn     (rstn),
    .port     (p1),
    .grant    (grant[1]),
    .fault_in (m.fault),
    .resp_sel (resp_sel[1]),
    .rdata_in (m.rdata),
    .pend     (pend[1]),
    .addr     (s_addr[1]),
    .w_rb     (s_w_rb[1]),
    .acc      (s_acc[1]),
    .wdata    (s_wdata[1])
  );

  // rr only breaks ties; a lone pending port always wins immediately.
  always_comb begin
    any         = |pend;
    sel         = (&pend) ? rr : port_idx_t'(pend[1]);
    grant       = '0;
    if (rstn && any) begin
      grant[sel] = 1'b1;
    end
    resp_sel[0] = m.resp & (owner == port_idx_t'(0));
    resp_sel[1] = m.resp & (owner == port_idx_t'(1));
  end

  always_comb begin
    m.req   = rstn & any;
    m.addr  = hold_addr;
    m.w_rb  = hold_w_rb;
    m.acc   = hold_acc;
    m.wdata = hold_wdata;
    if (!rstn) begin
      m.addr  = '0;
      m.w_rb  = 1'b0;
      m.acc   = '0;
      m.wdata = '0;
    end else if (any) begin
      m.addr  = s_addr[sel];
      m.w_rb  = s_w_rb[sel];
      m.acc   = s_acc[sel];
      m.wdata = s_wdata[sel];
    end
  end

  // The hold registers keep the controller-side fields stable between grants.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr         <= '0;
      owner      <= '0;
      hold_addr  <= '0;
      hold_w_rb  <= 1'b0;
      hold_acc   <= '0;
      hold_wdata <= '0;
    end else if (m.req) begin
      rr         <= ~sel;
      hold_addr  <= s_addr[sel];
      hold_w_rb  <= s_w_rb[sel];
      hold_acc   <= s_acc[sel];
      hold_wdata <= s_wdata[sel];
      if (!m.fault) begin
        owner <= sel;
      end
    end
  end

endmodule

// File: tb/tb_dbgtcm_arbiter.sv
// Bench for dbgtcm_arbiter: a small TCM controller stand-in plus a transaction-level
// reference of buffering, round-robin choice and completions, fed directed and random traffic.
module tb_dbgtcm_arbiter;
  import dbgtcm_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic inject;
  logic env_clr;

  always #5 clk = ~clk;

  dbgtcm_arbiter_if p0_bus ();
  dbgtcm_arbiter_if p1_bus ();
  dbgtcm_arbiter_if m_bus ();

  dbgtcm_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .p0   (p0_bus),
    .p1   (p1_bus),
    .m    (m_bus)
  );

  function automatic logic [7:0] seed_byte(input int a);
    case (a)
      16:      return 8'h44;
      17:      return 8'h33;
      18:      return 8'h22;
      19:      return 8'h11;
      default: return 8'(a * 37 + 5);
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] acc);
    return (acc == 2'd0) ? 1 : (acc == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [7:0] a, input logic [1:0] acc);
    case (acc)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  // TCM controller stand-in: fault in the request cycle, data one cycle later.
  logic [7:0]             tcm_mem [DBGTCM_SIZE];
  logic [DBGTCM_SIZE-1:0] tcm_written;
  logic                   tcm_fault;
  logic                   resp_q;
  logic [31:0]            rdata_q;

  function automatic logic [31:0] env_read(input logic [7:0] a, input logic [1:0] acc);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (i < nbytes(acc))
        r[8*i +: 8] = tcm_written[int'(a) + i] ? tcm_mem[int'(a) + i] : seed_byte(int'(a) + i);
    return r;
  endfunction

  assign tcm_fault    = m_bus.req & misaligned(m_bus.addr, m_bus.acc);
  assign m_bus.fault  = tcm_fault;
  assign m_bus.resp   = resp_q | inject;
  assign m_bus.rdata  = rdata_q;
  assign m_bus.busy   = 1'b0;

  always @(posedge clk) begin
    if (env_clr) begin
      tcm_written <= '0;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      resp_q <= 1'b0;
      if (m_bus.req && !tcm_fault) begin
        resp_q  <= 1'b1;
        rdata_q <= env_read(m_bus.addr, m_bus.acc);
        if (m_bus.w_rb)
          for (int i = 0; i < 4; i++)
            if (i < nbytes(m_bus.acc)) begin
              tcm_mem[int'(m_bus.addr) + i]     <= m_bus.wdata[8*i +: 8];
              tcm_written[int'(m_bus.addr) + i] <= 1'b1;
            end
      end
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [DBGTCM_SIZE];
  bit          mp_pend [2];
  logic [7:0]  mp_addr [2];
  logic        mp_w    [2];
  logic [1:0]  mp_acc  [2];
  logic [31:0] mp_wd   [2];
  bit          due_resp  [2];
  bit          due_fault [2];
  bit          due_rd    [2];
  logic [31:0] due_data  [2];
  bit          turn;
  int          obs_done  [2];
  int          obs_fault [2];
  logic [31:0] last_rdata [2];
  int          n_pass;
  int          n_total;

  function automatic logic [31:0] ref_read(input logic [7:0] a, input logic [1:0] acc);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbytes(acc); i++) r[8*i +: 8] = ref_mem[int'(a) + i];
    return r;
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [1:0] acc, input logic [31:0] d);
    for (int i = 0; i < nbytes(acc); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic modelStep();
    logic        o_resp [2], o_fault [2], o_busy [2], o_req [2], o_w [2];
    logic [31:0] o_rdata [2], o_wd [2];
    logic [7:0]  o_addr [2];
    logic [1:0]  o_acc [2];
    bit          exp_busy [2];
    bit          n_resp [2], n_fault [2], n_rd [2];
    logic [31:0] n_data [2];
    int          g;
    o_resp[0] = p0_bus.resp;   o_resp[1] = p1_bus.resp;
    o_fault[0] = p0_bus.fault; o_fault[1] = p1_bus.fault;
    o_busy[0] = p0_bus.busy;   o_busy[1] = p1_bus.busy;
    o_rdata[0] = p0_bus.rdata; o_rdata[1] = p1_bus.rdata;
    o_req[0] = p0_bus.req;     o_req[1] = p1_bus.req;
    o_addr[0] = p0_bus.addr;   o_addr[1] = p1_bus.addr;
    o_w[0] = p0_bus.w_rb;      o_w[1] = p1_bus.w_rb;
    o_acc[0] = p0_bus.acc;     o_acc[1] = p1_bus.acc;
    o_wd[0] = p0_bus.wdata;    o_wd[1] = p1_bus.wdata;
    for (int n = 0; n < 2; n++) begin
      obs_done[n]  += int'(o_resp[n] | o_fault[n]);
      obs_fault[n] += int'(o_fault[n]);
      if (o_resp[n]) last_rdata[n] = o_rdata[n];
    end
    if (!rstn) begin
      for (int n = 0; n < 2; n++)
        checkOutput($sformatf("rst_p%0d_out", n),
                    64'({o_resp[n], o_fault[n], o_busy[n], o_rdata[n]}), 64'(0));
      checkOutput("rst_m_out",
                  64'({m_bus.req, m_bus.addr, m_bus.w_rb, m_bus.acc, m_bus.wdata}), 64'(0));
      mp_pend   = '{default: 0};
      due_resp  = '{default: 0};
      due_fault = '{default: 0};
      turn      = 1'b0;
      return;
    end
    for (int n = 0; n < 2; n++) begin
      exp_busy[n] = mp_pend[n] | due_resp[n];
      checkOutput($sformatf("p%0d_busy", n), 64'(o_busy[n]), 64'(exp_busy[n]));
      checkOutput($sformatf("p%0d_resp", n), 64'(o_resp[n]), 64'(due_resp[n]));
      checkOutput($sformatf("p%0d_fault", n), 64'(o_fault[n]), 64'(due_fault[n]));
      if (due_resp[n] && due_rd[n])
        checkOutput($sformatf("p%0d_rdata", n), 64'(o_rdata[n]), 64'(due_data[n]));
      n_resp[n] = 1'b0; n_fault[n] = 1'b0; n_rd[n] = 1'b0; n_data[n] = '0;
    end
    checkOutput("m_req", 64'(m_bus.req), 64'(mp_pend[0] | mp_pend[1]));
    if (mp_pend[0] || mp_pend[1]) begin
      g = (mp_pend[0] && mp_pend[1]) ? int'(turn) : (mp_pend[1] ? 1 : 0);
      checkOutput($sformatf("m_fields_p%0d", g),
                  64'({m_bus.addr, m_bus.w_rb, m_bus.acc, m_bus.wdata}),
                  64'({mp_addr[g], mp_w[g], mp_acc[g], mp_wd[g]}));
      if (misaligned(mp_addr[g], mp_acc[g])) begin
        n_fault[g] = 1'b1;
      end else begin
        n_resp[g] = 1'b1;
        n_rd[g]   = !mp_w[g];
        if (mp_w[g]) ref_write(mp_addr[g], mp_acc[g], mp_wd[g]);
        else         n_data[g] = ref_read(mp_addr[g], mp_acc[g]);
      end
      mp_pend[g] = 1'b0;
      turn       = (g == 0);
    end
    due_resp = n_resp; due_fault = n_fault; due_rd = n_rd; due_data = n_data;
    for (int n = 0; n < 2; n++)
      if (o_req[n] && !exp_busy[n]) begin
        mp_pend[n] = 1'b1;
        mp_addr[n] = o_addr[n]; mp_w[n] = o_w[n]; mp_acc[n] = o_acc[n]; mp_wd[n] = o_wd[n];
      end
  endtask

  task automatic setPort(input int n, input logic [7:0] a, input logic w,
                         input logic [1:0] acc, input logic [31:0] wd);
    if (n == 0) begin
      p0_bus.addr = a; p0_bus.w_rb = w; p0_bus.acc = acc; p0_bus.wdata = wd;
    end else begin
      p1_bus.addr = a; p1_bus.w_rb = w; p1_bus.acc = acc; p1_bus.wdata = wd;
    end
  endtask

  task automatic randPort(input int n);
    setPort(n, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)), $urandom);
  endtask

  task automatic applyStimulus(input bit rq0, input bit rq1);
    p0_bus.req = rq0;
    p1_bus.req = rq1;
    @(negedge clk);
    modelStep();
    @(posedge clk);
    #1;
    p0_bus.req = 1'b0;
    p1_bus.req = 1'b0;
    inject     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    int c0, c1, f1;
    n_pass = 0; n_total = 0; turn = 1'b0;
    rstn = 1'b0; inject = 1'b0; env_clr = 1'b1;
    mp_pend = '{default: 0}; due_resp = '{default: 0}; due_fault = '{default: 0};
    due_rd = '{default: 0}; due_data = '{default: 0};
    obs_done = '{default: 0}; obs_fault = '{default: 0}; last_rdata = '{default: 0};
    for (int i = 0; i < DBGTCM_SIZE; i++) ref_mem[i] = seed_byte(i);
    setPort(0, 8'h0, 1'b0, 2'd0, 32'h0);
    setPort(1, 8'h0, 1'b0, 2'd0, 32'h0);
    p0_bus.req = 1'b0; p1_bus.req = 1'b0;
    $display("[TB] reset and stray m_resp after release");
    idle(1);
    env_clr = 1'b0;
    idle(2);
    rstn = 1'b1; inject = 1'b1;
    applyStimulus(1'b0, 1'b0);
    idle(1);

    $display("[TB] single read");
    c0 = obs_done[0];
    setPort(0, 8'h10, 1'b0, BUS_ACC_4B, 32'h0);
    applyStimulus(1'b1, 1'b0);
    idle(3);
    checkOutput("single_read_count", 64'(obs_done[0] - c0), 64'(1));
    checkOutput("single_read_data", 64'(last_rdata[0]), 64'(32'h11223344));

    $display("[TB] contention after reset");
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    setPort(0, 8'h03, 1'b1, BUS_ACC_1B, 32'h000000A5);
    setPort(1, 8'h00, 1'b0, BUS_ACC_4B, 32'h0);
    applyStimulus(1'b1, 1'b1);
    idle(4);
    checkOutput("contend_p1_byte3", 64'(last_rdata[1][31:24]), 64'(8'hA5));
    setPort(0, 8'h40, 1'b0, BUS_ACC_4B, 32'h0);
    setPort(1, 8'h44, 1'b1, BUS_ACC_4B, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b1);
    idle(4);

    $display("[TB] fault on p1 with p0 traffic");
    c0 = obs_done[0]; f1 = obs_fault[1]; c1 = obs_done[1];
    setPort(1, 8'h02, 1'b0, BUS_ACC_4B, 32'h0);
    setPort(0, 8'h20, 1'b0, BUS_ACC_4B, 32'h0);
    applyStimulus(1'b1, 1'b1);
    idle(4);
    checkOutput("fault_p1_faults", 64'(obs_fault[1] - f1), 64'(1));
    checkOutput("fault_p1_completions", 64'(obs_done[1] - c1), 64'(1));
    checkOutput("fault_p0_completions", 64'(obs_done[0] - c0), 64'(1));

    $display("[TB] request while busy");
    c0 = obs_done[0];
    setPort(0, 8'h30, 1'b0, BUS_ACC_4B, 32'h0);
    applyStimulus(1'b1, 1'b0);
    setPort(0, 8'h34, 1'b0, BUS_ACC_4B, 32'h0);
    applyStimulus(1'b1, 1'b0);
    idle(4);
    checkOutput("busy_violation_count", 64'(obs_done[0] - c0), 64'(1));

    $display("[TB] reset during grant cycle");
    c0 = obs_done[0];
    setPort(0, 8'h50, 1'b0, BUS_ACC_4B, 32'h0);
    applyStimulus(1'b1, 1'b0);
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0);
    rstn = 1'b1; inject = 1'b1;
    applyStimulus(1'b0, 1'b0);
    idle(3);
    checkOutput("reset_drop_count", 64'(obs_done[0] - c0), 64'(0));

    $display("[TB] back-to-back streaming");
    c0 = obs_done[0]; c1 = obs_done[1];
    for (int i = 0; i < 300; i++) begin
      randPort(0);
      randPort(1);
      applyStimulus(1'b1, 1'b1);
    end
    idle(4);
    checkOutput("stream_p0_ge50", 64'((obs_done[0] - c0) >= 50), 64'(1));
    checkOutput("stream_p1_ge50", 64'((obs_done[1] - c1) >= 50), 64'(1));

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      randPort(0);
      randPort(1);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dbgtcm_arbiter.md
# dbgtcm_arbiter

Two-port arbiter that shares the single-ported debug TCM controller between port 0 (CPU data bus) and port 1 (debug transport / host access). Each port has a one-entry request buffer. Buffered requests are granted round-robin, one per cycle, onto the TCM controller's req/resp/fault interface. The arbiter returns resp+rdata or fault to the port that issued the request. It sits between the MCU bus fabric / debug module and `dbgtcm_controller`.

## Interface
- `AW`, default `$clog2(`DBGTCM_SIZE)`: byte address width of TCM port.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `pN_addr`  in  AW  port N byte address (N = 0, 1).
- `pN_w_rb`  in  1  port N 1 = write, 0 = read.
- `pN_acc`  in  `BUS_ACC_WIDTH`  port N access size (`BUS_ACC_1B/2B/4B`).
- `pN_wdata`  in  `BUS_WIDTH`  port N write data.
- `pN_req`  in  1  port N single-cycle request strobe.
- `pN_rdata`  out  `BUS_WIDTH`  port N read data; valid with `pN_resp`.
- `pN_resp`  out  1  port N one-cycle completion pulse.
- `pN_fault`  out  1  port N one-cycle fault pulse.
- `pN_busy`  out  1  port N buffer occupied or request in flight.
- `m_addr`, `m_w_rb`, `m_acc`, `m_wdata`, `m_req`  out  (as above)  to TCM controller.
- `m_rdata`, `m_resp`, `m_fault`  in  (as above)  from TCM controller. `m_resp` arrives the cycle after `m_req`. `m_fault` is combinational in the `m_req` cycle.

## Operation
- Per-port state: `pend` (buffer full), captured addr/w_rb/acc/wdata, and `infl` (granted, awaiting completion). `pN_busy = pend | infl`.
- Capture: `pN_req` while `pN_busy==0` registers all fields and sets `pend`.
  - `pN_req` while busy is a protocol violation. It is ignored: no state change, and no resp or fault is produced for it.
- Arbitration each cycle among ports with `pend`:
  - Only one pending: grant it.
  - Both pending: grant port indicated by `rr`.
  - After any grant, `rr` points to the non-granted port.
  - Reset value `rr = 0`.
- Grant cycle:
  - `m_req=1` with the captured fields; granted port `pend<=0`.
  - If `m_fault==1`: the port gets `pN_fault=1` next cycle, with `infl` never set.
  - Otherwise the port sets `infl<=1`, and `owner<=N` is recorded.
- Completion: when `m_resp==1`, the `owner` port gets `pN_resp=1`, `pN_rdata=m_rdata` in that same cycle (combinational route) and `infl<=0`.
- Back-to-back grants are allowed, since the TCM is one-deep pipelined. A grant in cycle T+1 while the T grant completes is legal; `owner` is updated each grant.
- Upstream wdata/acc are not checked; all fault decisions come from `m_fault`.
- Idle: `m_req=0`. `m_addr/m_acc/m_wdata/m_w_rb` hold the last driven value; they are don't-care when `m_req=0`.

## Timing
- Reset, all outputs: `pN_resp=0`, `pN_fault=0`, `pN_busy=0`, `pN_rdata=0`, `m_req=0`, `m_addr=0`, `m_w_rb=0`, `m_acc=0`, `m_wdata=0`. All `pend/infl=0`, `rr=0`, `owner=0`.
- Reset asserted mid-operation: buffered and in-flight requests are dropped with no resp/fault. An `m_resp` in the first cycle after reset release is ignored.
- Uncontended latency:
  - req at cycle T, `m_req` at T+1, `pN_resp` at T+2.
  - A fault is reported at T+2 as `pN_fault`.
- Contended: loser is granted in the cycle after the winner. Its resp is one cycle later than the winner's.
- Fastest reissue: port may strobe `pN_req` in the cycle after its `pN_resp`/`pN_fault` (busy is already 0 that cycle).
- Simultaneous `p0_req` and `p1_req` at T with `rr=0`: port 0 gets `m_req` at T+1, port 1 at T+2, and `rr=0` again after that.
- Exactly one of `pN_resp`/`pN_fault` per accepted request; never both in the same cycle for one port.

## Structure
- Access-size and width macros (`BUS_ACC_*`, `BUS_WIDTH`, `BUS_ACC_WIDTH`, `DBGTCM_SIZE`) come from `femto.vh`. Add `DBGTCM_ARB_PORTS` = 2 there.
- One sub-module is natural: `dbgtcm_arb_slot`, instantiated per port. It holds the capture registers, `pend`, `infl`, and the busy/ignore logic.
- The top level holds `rr`, `owner`, the grant mux, and the response demux.

## Test plan
- Single read: preload word 0x11223344 at 0x10; p0 4B read req at T -> `m_req` at T+1 with addr 0x10; `p0_resp=1`, `p0_rdata=0x11223344` at T+2; `p0_busy` low at T+2.
- Contention: p0 write 0xA5 (1B, addr 0x3) and p1 read 4B addr 0x0, same cycle after reset -> p0 granted first, p1 one cycle later; p1 rdata byte 3 = 0xA5. Repeat simultaneous reqs -> p1 granted first (`rr` alternates).
- Fault: p1 4B access at addr 0x2 -> `m_fault` in grant cycle; `p1_fault=1` for exactly one cycle; no `p1_resp`; p0 traffic is unaffected.
- Busy violation: p0 reqs on consecutive cycles T, T+1 -> only the T request reaches `m_req`; exactly one `p0_resp`.
- Back-to-back streaming: p0 and p1 each reissue immediately after completion for 50 requests -> `m_req` is never idle while any port is pending; each port gets 50 completions in order.
- Reset mid-flight: assert `rstn=0` in the `m_req` cycle -> no `pN_resp`/`pN_fault`, all outputs 0, `busy=0` after reset.
